// File: rtl/risc_pkg.sv
// Shared definitions for the 16-bit RISC core: bus widths, the HALT opcode
// and the fetch-stage state encoding.
package risc_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;

  // Opcode in IR[15:12] that stops instruction fetch.
  localparam logic [3:0] HALT_OP = 4'hF;

  typedef enum logic [2:0] {
    FS_IDLE   = 3'd0,
    FS_REQ    = 3'd1,
    FS_WAIT   = 3'd2,
    FS_HOLD   = 3'd3,
    FS_HALTED = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads the word at PC_addr from synchronous
// instruction memory, latches it into IR and hands it to the decoder over a
// valid/ready handshake. Strobes PC_inc once per non-HALT fetch and parks in
// HALTED after a HALT opcode has been consumed.
module instr_fetch #(
  parameter int         ADDR_W  = risc_pkg::ADDR_W,
  parameter int         INSTR_W = risc_pkg::INSTR_W,
  parameter logic [3:0] HALT_OP = risc_pkg::HALT_OP
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               fetch_en,
  input  logic [ADDR_W-1:0]  PC_addr,
  output logic               PC_inc,
  output logic               PC_clr,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_rd,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] IR,
  output logic [ADDR_W-1:0]  IR_addr,
  output logic               IR_valid,
  input  logic               IR_ready,
  output logic               halted
);

  import risc_pkg::*;

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  ir_addr_q, ir_addr_d;
  logic               ir_valid_q, ir_valid_d;
  logic               halt_flag_q, halt_flag_d;
  logic               halted_q, halted_d;
  logic [3:0]         opcode;

  // The memory is always addressed by the PC; imem_rd qualifies the access.
  assign imem_addr = PC_addr;
  assign PC_clr    = clr;
  assign opcode    = imem_data[INSTR_W-1 -: 4];

  assign IR       = ir_q;
  assign IR_addr  = ir_addr_q;
  assign IR_valid = ir_valid_q;
  assign halted   = halted_q;

  // Next-state logic plus the two combinational strobes (PC_inc, imem_rd).
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    ir_d        = ir_q;
    ir_addr_d   = ir_addr_q;
    ir_valid_d  = ir_valid_q;
    halt_flag_d = halt_flag_q;
    halted_d    = halted_q;
    PC_inc      = 1'b0;
    imem_rd     = 1'b0;

    case (state_q)
      FS_IDLE: begin
        if (fetch_en) state_d = FS_REQ;
      end
      FS_REQ: begin
        imem_rd = 1'b1;
        addr_d  = PC_addr;
        state_d = FS_WAIT;
      end
      FS_WAIT: begin
        ir_d       = imem_data;
        ir_addr_d  = addr_q;
        ir_valid_d = 1'b1;
        if (opcode != HALT_OP) begin
          PC_inc      = 1'b1;
          halt_flag_d = 1'b0;
        end else begin
          halt_flag_d = 1'b1;
        end
        state_d = FS_HOLD;
      end
      FS_HOLD: begin
        if (IR_ready) begin
          ir_valid_d = 1'b0;
          if (halt_flag_q) begin
            halted_d = 1'b1;
            state_d  = FS_HALTED;
          end else if (fetch_en) begin
            state_d = FS_REQ;
          end else begin
            state_d = FS_IDLE;
          end
        end
      end
      FS_HALTED: begin
        state_d = FS_HALTED;
      end
      default: begin
        state_d = FS_IDLE;
      end
    endcase

    // A clear in flight suppresses this cycle's strobes so the PC and
    // memory never see a half-finished fetch.
    if (clr) begin
      PC_inc  = 1'b0;
      imem_rd = 1'b0;
    end
  end

  // State, IR and address registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= FS_IDLE;
      addr_q      <= '0;
      ir_q        <= '0;
      ir_addr_q   <= '0;
      ir_valid_q  <= 1'b0;
      halt_flag_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      ir_q        <= ir_d;
      ir_addr_q   <= ir_addr_d;
      ir_valid_q  <= ir_valid_d;
      halt_flag_q <= halt_flag_d;
      halted_q    <= halted_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural PC and a synchronous
// instruction memory model.
`timescale 1ns/1ps
module tb_instr_fetch;

  logic        clk;
  logic        clr;
  logic        fetch_en;
  logic [7:0]  PC_addr;
  logic        PC_inc;
  logic        PC_clr;
  logic [7:0]  imem_addr;
  logic        imem_rd;
  logic [15:0] imem_data;
  logic [15:0] IR;
  logic [7:0]  IR_addr;
  logic        IR_valid;
  logic        IR_ready;
  logic        halted;

  logic [15:0] mem [0:255];
  logic        pc_load;
  logic [7:0]  pc_load_val;
  int          inc_cnt;
  int          rd_cnt;
  int          total;
  int          bad;
  int          base_inc;
  int          base_rd;

  instr_fetch dut (
    .clk       (clk),
    .clr       (clr),
    .fetch_en  (fetch_en),
    .PC_addr   (PC_addr),
    .PC_inc    (PC_inc),
    .PC_clr    (PC_clr),
    .imem_addr (imem_addr),
    .imem_rd   (imem_rd),
    .imem_data (imem_data),
    .IR        (IR),
    .IR_addr   (IR_addr),
    .IR_valid  (IR_valid),
    .IR_ready  (IR_ready),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program counter model: clear, preset, or increment on strobe.
  always @(posedge clk) begin
    if (PC_clr)       PC_addr <= 8'h00;
    else if (pc_load) PC_addr <= pc_load_val;
    else if (PC_inc)  PC_addr <= PC_addr + 8'h01;
  end

  // Synchronous memory: data one cycle after the read strobe.
  always @(posedge clk) begin
    if (imem_rd) imem_data <= mem[imem_addr];
  end

  // Strobe counters.
  initial begin
    inc_cnt = 0;
    rd_cnt  = 0;
  end
  always @(posedge clk) begin
    if (PC_inc)  inc_cnt <= inc_cnt + 1;
    if (imem_rd) rd_cnt  <= rd_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    clr         = 1'b1;
    fetch_en    = 1'b0;
    IR_ready    = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = 8'h00;
    PC_addr     = 8'h00;
    imem_data   = 16'h0000;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h1234;
    mem[8'h01] = 16'h5678;
    mem[8'h02] = 16'hF000;

    // Reset state
    tick(); tick();
    chk("rst_ir", IR, 16'h0000);
    chk("rst_ir_addr", IR_addr, 8'h00);
    chk("rst_valid", IR_valid, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_pc_clr", PC_clr, 1'b1);
    chk("rst_pc_inc", PC_inc, 1'b0);
    chk("rst_imem_rd", imem_rd, 1'b0);

    // Basic streaming fetch
    clr = 1'b0; fetch_en = 1'b1; IR_ready = 1'b1;
    chk("pc_clr_rel", PC_clr, 1'b0);
    base_inc = inc_cnt;
    tick();                                   // cycle 1: REQ
    chk("c1_rd", imem_rd, 1'b1);
    chk("c1_addr", imem_addr, 8'h00);
    chk("c1_valid", IR_valid, 1'b0);
    tick();                                   // cycle 2: WAIT
    chk("c2_inc", PC_inc, 1'b1);
    chk("c2_rd", imem_rd, 1'b0);
    tick();                                   // cycle 3: HOLD
    chk("c3_ir", IR, 16'h1234);
    chk("c3_ir_addr", IR_addr, 8'h00);
    chk("c3_valid", IR_valid, 1'b1);
    chk("c3_pc", PC_addr, 8'h01);
    chk("c3_inc", PC_inc, 1'b0);
    tick();                                   // cycle 4: REQ
    chk("c4_valid", IR_valid, 1'b0);
    chk("c4_addr", imem_addr, 8'h01);
    chk("c4_rd", imem_rd, 1'b1);
    tick();                                   // cycle 5: WAIT
    IR_ready = 1'b0;
    tick();                                   // cycle 6: HOLD
    chk("c6_ir", IR, 16'h5678);
    chk("c6_ir_addr", IR_addr, 8'h01);
    chk("inc_per_instr", inc_cnt - base_inc, 2);

    // Backpressure for 5 cycles
    base_rd = rd_cnt;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ir", IR, 16'h5678);
      chk("bp_valid", IR_valid, 1'b1);
      chk("bp_rd", imem_rd, 1'b0);
      chk("bp_inc", PC_inc, 1'b0);
      tick();
    end
    chk("bp_rd_cnt", rd_cnt - base_rd, 0);
    chk("bp_pc", PC_addr, 8'h02);

    // HALT instruction at 0x02
    IR_ready = 1'b1;
    tick();                                   // REQ
    chk("h_addr", imem_addr, 8'h02);
    chk("h_valid_drop", IR_valid, 1'b0);
    base_inc = inc_cnt;
    tick();                                   // WAIT with F000
    chk("h_no_inc", PC_inc, 1'b0);
    tick();                                   // HOLD
    chk("h_ir", IR, 16'hF000);
    chk("h_ir_addr", IR_addr, 8'h02);
    chk("h_not_yet", halted, 1'b0);
    tick();                                   // HALTED
    chk("h_halted", halted, 1'b1);
    chk("h_valid", IR_valid, 1'b0);
    base_rd = rd_cnt;
    for (int i = 0; i < 5; i++) begin
      chk("h_rd", imem_rd, 1'b0);
      chk("h_inc", PC_inc, 1'b0);
      tick();
    end
    chk("h_rd_cnt", rd_cnt - base_rd, 0);
    chk("h_inc_cnt", inc_cnt - base_inc, 0);
    chk("h_pc", PC_addr, 8'h02);

    // Wrap from 0xFF to 0x00
    mem[8'hFF] = 16'h0AAA;
    mem[8'h00] = 16'h0BBB;
    clr = 1'b1; fetch_en = 1'b0;
    tick();
    chk("w_clr_halted", halted, 1'b0);
    clr = 1'b0; pc_load = 1'b1; pc_load_val = 8'hFF;
    tick();
    pc_load = 1'b0; fetch_en = 1'b1; IR_ready = 1'b1;
    tick();                                   // REQ
    chk("w_addr0", imem_addr, 8'hFF);
    tick(); tick();                           // WAIT, HOLD
    chk("w_ir0", IR, 16'h0AAA);
    chk("w_ir_addr0", IR_addr, 8'hFF);
    tick();                                   // REQ
    chk("w_addr1", imem_addr, 8'h00);
    tick(); tick();
    chk("w_ir1", IR, 16'h0BBB);
    chk("w_ir_addr1", IR_addr, 8'h00);

    // Clear asserted during WAIT
    tick();                                   // REQ @ 0x01
    chk("cw_addr", imem_addr, 8'h01);
    tick();                                   // WAIT
    clr = 1'b1;
    #1;
    chk("cw_inc_gated", PC_inc, 1'b0);
    chk("cw_pc_clr", PC_clr, 1'b1);
    tick();
    chk("cw_valid", IR_valid, 1'b0);
    chk("cw_ir", IR, 16'h0000);
    chk("cw_pc", PC_addr, 8'h00);
    chk("cw_inc", PC_inc, 1'b0);
    clr = 1'b0;
    tick();                                   // REQ
    chk("cw_restart_addr", imem_addr, 8'h00);
    chk("cw_restart_rd", imem_rd, 1'b1);

    // fetch_en dropped during WAIT
    tick();                                   // WAIT
    fetch_en = 1'b0;
    tick();                                   // HOLD
    chk("fe_ir", IR, 16'h0BBB);
    chk("fe_valid", IR_valid, 1'b1);
    tick();                                   // IDLE
    chk("fe_valid_drop", IR_valid, 1'b0);
    chk("fe_pc", PC_addr, 8'h01);
    base_rd = rd_cnt;
    for (int i = 0; i < 3; i++) begin
      chk("fe_idle_rd", imem_rd, 1'b0);
      tick();
    end
    chk("fe_idle_rd_cnt", rd_cnt - base_rd, 0);
    fetch_en = 1'b1;
    tick();                                   // REQ
    chk("fe_resume_addr", imem_addr, 8'h01);
    tick(); tick();
    chk("fe_resume_ir", IR, 16'h5678);
    chk("fe_resume_ir_addr", IR_addr, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
